// File: rtl/pio_edge_pkg.sv
// ----------------------------------------------------------------------------
// pio_edge_pkg
//  Shared constants for the edge-capturing, debounced input PIO.
//  Holds the Avalon-MM register address map and the address width.
// ----------------------------------------------------------------------------
package pio_edge_pkg;

    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] pio_addr_t;

    // Register map of the slave. Addresses 6 and 7 read as zero.
    localparam pio_addr_t ADDR_DATA      = 3'd0;
    localparam pio_addr_t ADDR_RISE_EN   = 3'd1;
    localparam pio_addr_t ADDR_IRQ_MASK  = 3'd2;
    localparam pio_addr_t ADDR_EDGE_CAP  = 3'd3;
    localparam pio_addr_t ADDR_FALL_EN   = 3'd4;
    localparam pio_addr_t ADDR_DEB_LIMIT = 3'd5;

    // Returns 1 when a bus cycle is a write to register 'reg_addr'.
    function automatic logic is_write_to(input logic      wr,
                                         input pio_addr_t addr,
                                         input pio_addr_t reg_addr);
        return wr && (addr == reg_addr);
    endfunction

endpackage : pio_edge_pkg

// File: rtl/pio_in_debounce.sv
// ----------------------------------------------------------------------------
// pio_in_debounce
//  One input channel: SYNC_STAGES-deep synchroniser, debounce counter and a
//  delayed copy of the debounced level for edge detection.
//  Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   din        in   raw asynchronous input bit
//   deb_limit  in   DEB_W  debounce length (shared by all channels)
//   deb_o      out  debounced level
//   deb_dly_o  out  debounced level delayed by one clock
// ----------------------------------------------------------------------------
module pio_in_debounce #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_W       = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             din,
    input  logic [DEB_W-1:0] deb_limit,
    output logic             deb_o,
    output logic             deb_dly_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   deb_q;
    logic                   deb_d;
    logic                   dly_q;
    logic                   dly_d;
    logic [DEB_W-1:0]       cnt_q;
    logic [DEB_W-1:0]       cnt_d;
    logic                   sync_s;

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign deb_o     = deb_q;
    assign deb_dly_o = dly_q;

    // Synchroniser shift: bit 0 samples the pin, the top bit feeds the filter.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Debounce filter: the synchronised level must disagree with the current
    // output for deb_limit+1 consecutive clocks before it is accepted. The
    // counter never passes deb_limit, and a '>=' compare means a limit lowered
    // below the running count takes effect on the very next clock.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync_s == deb_q) begin
            cnt_d = {DEB_W{1'b0}};
        end else if (cnt_q >= deb_limit) begin
            deb_d = sync_s;
            cnt_d = {DEB_W{1'b0}};
        end else begin
            cnt_d = cnt_q + DEB_W'(1'b1);
        end
        dly_d = deb_q;
    end

    // Channel state flops; deb and its delayed copy share the reset value so
    // reset release never looks like an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            deb_q  <= RESET_VAL;
            dly_q  <= RESET_VAL;
            cnt_q  <= {DEB_W{1'b0}};
        end else begin
            sync_q <= sync_d;
            deb_q  <= deb_d;
            dly_q  <= dly_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule : pio_in_debounce

// File: rtl/pio_edge_capture_deb.sv
// ----------------------------------------------------------------------------
// pio_edge_capture_deb
//  Avalon-MM input PIO with WIDTH channels, each synchronised and debounced,
//  plus runtime rise/fall capture enables, write-1-to-clear edge capture and
//  a masked interrupt output.
//  Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   3      register select
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data
//   in_port     in   WIDTH  raw asynchronous inputs
//   readdata    out  32     registered read data, zero-extended above WIDTH
//   irq         out  1      |(edge_capture & irq_mask)
// ----------------------------------------------------------------------------
module pio_edge_capture_deb
    import pio_edge_pkg::*;
#(
    parameter int               WIDTH        = 1,
    parameter int               SYNC_STAGES  = 2,
    parameter int               DEB_W        = 16,
    parameter logic [DEB_W-1:0] DEB_RESET    = {DEB_W{1'b0}},
    parameter logic [WIDTH-1:0] IN_RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [WIDTH-1:0] deb_s;
    logic [WIDTH-1:0] deb_dly_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] w1c_s;
    logic             wr_s;

    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] rise_en_d;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] fall_en_d;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] edge_capture_d;
    logic [DEB_W-1:0] deb_limit_q;
    logic [DEB_W-1:0] deb_limit_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    // Upper write-data bits beyond WIDTH/DEB_W are intentionally ignored.
    logic unused_wdata_s;
    assign unused_wdata_s = ^writedata;

    assign wr_s = chipselect & ~write_n;

    // Per-channel synchroniser and debounce filter, all sharing one limit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_in_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_W       (DEB_W),
            .RESET_VAL   (IN_RESET_VAL[i])
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .din       (in_port[i]),
            .deb_limit (deb_limit_q),
            .deb_o     (deb_s[i]),
            .deb_dly_o (deb_dly_s[i])
        );
    end

    // Edge detection and capture; a new edge beats a same-cycle W1C.
    always_comb begin
        rise_s = deb_s & ~deb_dly_s;
        fall_s = ~deb_s & deb_dly_s;
        set_s  = (rise_s & rise_en_q) | (fall_s & fall_en_q);
        if (is_write_to(wr_s, address, ADDR_EDGE_CAP)) begin
            w1c_s = writedata[WIDTH-1:0];
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
        edge_capture_d = (edge_capture_q & ~w1c_s) | set_s;
    end

    // Next values of the read/write control registers.
    always_comb begin
        if (is_write_to(wr_s, address, ADDR_RISE_EN)) begin
            rise_en_d = writedata[WIDTH-1:0];
        end else begin
            rise_en_d = rise_en_q;
        end
        if (is_write_to(wr_s, address, ADDR_FALL_EN)) begin
            fall_en_d = writedata[WIDTH-1:0];
        end else begin
            fall_en_d = fall_en_q;
        end
        if (is_write_to(wr_s, address, ADDR_IRQ_MASK)) begin
            irq_mask_d = writedata[WIDTH-1:0];
        end else begin
            irq_mask_d = irq_mask_q;
        end
        if (is_write_to(wr_s, address, ADDR_DEB_LIMIT)) begin
            deb_limit_d = writedata[DEB_W-1:0];
        end else begin
            deb_limit_d = deb_limit_q;
        end
    end

    // Read mux: reads have no side effects and are zero-extended to 32 bits.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            ADDR_DATA:      readdata_d[WIDTH-1:0] = deb_s;
            ADDR_RISE_EN:   readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_IRQ_MASK:  readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP:  readdata_d[WIDTH-1:0] = edge_capture_q;
            ADDR_FALL_EN:   readdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_DEB_LIMIT: readdata_d[DEB_W-1:0] = deb_limit_q;
            default:        readdata_d            = 32'd0;
        endcase
    end

    // Register file, capture register and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q      <= {WIDTH{1'b0}};
            fall_en_q      <= {WIDTH{1'b1}};
            irq_mask_q     <= {WIDTH{1'b0}};
            edge_capture_q <= {WIDTH{1'b0}};
            deb_limit_q    <= DEB_RESET;
            readdata_q     <= 32'd0;
        end else begin
            rise_en_q      <= rise_en_d;
            fall_en_q      <= fall_en_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            deb_limit_q    <= deb_limit_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // Interrupt is a pure function of two registers, so it is glitch-free.
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule : pio_edge_capture_deb

// File: tb/tb_pio_edge_capture_deb.sv
// ----------------------------------------------------------------------------
// tb_pio_edge_capture_deb
//  Directed scenarios followed by randomized traffic for a 4-channel,
//  idle-high instance. A reference model predicts readdata and irq every clock.
// ----------------------------------------------------------------------------
module tb_pio_edge_capture_deb;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    pio_edge_capture_deb #(
        .WIDTH        (4),
        .SYNC_STAGES  (SYNC),
        .DEB_W        (16),
        .DEB_RESET    (16'd0),
        .IN_RESET_VAL (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [3:0]  m_deb, m_prev, m_rise, m_fall, m_mask, m_cap;
    logic [15:0] m_lim;
    logic [31:0] m_rd;
    int          m_run [4];   // consecutive clocks the synced input disagreed
    logic [3:0]  m_pipe [$];  // pin samples still travelling through the synchroniser

    task automatic model_reset();
        m_deb  = 4'hF; m_prev = 4'hF;
        m_rise = 4'h0; m_fall = 4'hF; m_mask = 4'h0; m_cap = 4'h0;
        m_lim  = 16'd0; m_rd = 32'd0;
        for (int b = 0; b < 4; b++) m_run[b] = 0;
        m_pipe.delete();
        for (int k = 0; k < SYNC; k++) m_pipe.push_back(4'hF);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict from pre-edge state, let the DUT clock, compare.
    task automatic cycle();
        logic [3:0]  s, nd, setv, w1c, pin;
        logic [31:0] nrd;
        logic        wr;
        wr  = chipselect && !write_n;
        pin = in_port;
        s   = m_pipe[0];
        nd  = m_deb;
        for (int b = 0; b < 4; b++) begin
            if (s[b] != m_deb[b]) begin
                m_run[b] = m_run[b] + 1;
                if (m_run[b] > int'(m_lim)) begin
                    nd[b] = s[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        setv = (m_deb & ~m_prev & m_rise) | (~m_deb & m_prev & m_fall);
        w1c  = (wr && address == 3'd3) ? writedata[3:0] : 4'h0;
        case (address)
            3'd0: nrd = {28'd0, m_deb};
            3'd1: nrd = {28'd0, m_rise};
            3'd2: nrd = {28'd0, m_mask};
            3'd3: nrd = {28'd0, m_cap};
            3'd4: nrd = {28'd0, m_fall};
            3'd5: nrd = {16'd0, m_lim};
            default: nrd = 32'd0;
        endcase
        @(posedge clk);
        #1;
        m_rd   = nrd;
        m_cap  = (m_cap & ~w1c) | setv;
        m_prev = m_deb;
        m_deb  = nd;
        if (wr && address == 3'd1) m_rise = writedata[3:0];
        if (wr && address == 3'd2) m_mask = writedata[3:0];
        if (wr && address == 3'd4) m_fall = writedata[3:0];
        if (wr && address == 3'd5) m_lim  = writedata[15:0];
        void'(m_pipe.pop_front());
        m_pipe.push_back(pin);
        chk("readdata", readdata, m_rd);
        chk("irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        cycle();
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        cycle();
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; in_port = 4'hF;
        model_reset();
        #1;
        chk("reset_readdata", readdata, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        // Idle-high inputs at reset release: no spurious capture
        wr(3'd2, 32'h0000_000F);
        address = 3'd3;
        for (int i = 0; i < 100; i++) begin
            cycle();
            chk("t5_cap", readdata, 32'd0);
            chk("t5_irq", {31'd0, irq}, 32'd0);
        end
        rd(3'd4, 32'h0000_000F, "reset_fall_en");
        rd(3'd1, 32'h0000_0000, "reset_rise_en");
        rd(3'd5, 32'h0000_0000, "reset_deb_limit");

        // Unfiltered falling edge on bit0
        address = 3'd0;
        in_port = 4'hE;
        repeat (SYNC + 2) cycle();
        chk("t1_data", readdata, 32'h0000_000E);
        rd(3'd3, 32'h0000_0001, "t1_cap");
        wr(3'd3, 32'hFFFF_FFFF);
        in_port = 4'hF;
        repeat (6) cycle();
        rd(3'd3, 32'h0000_0000, "t1_rise_ignored");

        // 8-clock glitch against a 10-clock debounce
        wr(3'd5, 32'd10);
        address = 3'd0;
        in_port = 4'hB;
        repeat (8) cycle();
        in_port = 4'hF;
        repeat (20) cycle();
        chk("t2_data", readdata, 32'h0000_000F);
        rd(3'd3, 32'h0000_0000, "t2_cap");
        chk("t2_irq", {31'd0, irq}, 32'd0);

        // Rising capture, interrupt, W1C
        wr(3'd5, 32'd0); wr(3'd1, 32'd1); wr(3'd4, 32'd0); wr(3'd2, 32'd1);
        in_port = 4'hE; repeat (6) cycle();
        in_port = 4'hF; repeat (6) cycle();
        chk("t3_irq_set", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'h0000_0001, "t3_cap");
        wr(3'd3, 32'd1);
        chk("t3_irq_clr", {31'd0, irq}, 32'd0);

        // W1C in the same clock as a new set: set wins
        in_port = 4'hE; repeat (6) cycle();
        in_port = 4'hF; repeat (SYNC + 1) cycle();
        wr(3'd3, 32'd1);
        chk("t4_irq", {31'd0, irq}, 32'd1);
        rd(3'd3, 32'h0000_0001, "t4_cap");

        // Asynchronous reset mid-debounce
        wr(3'd3, 32'hF); wr(3'd5, 32'd10); wr(3'd1, 32'hA);
        in_port = 4'hD;
        repeat (SYNC + 5) cycle();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_readdata", readdata, 32'd0);
        chk("t6_irq", {31'd0, irq}, 32'd0);
        model_reset();
        in_port = 4'hF;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        rd(3'd5, 32'h0000_0000, "t6_deb_limit");
        rd(3'd1, 32'h0000_0000, "t6_rise_en");
        rd(3'd4, 32'h0000_000F, "t6_fall_en");
        rd(3'd0, 32'h0000_000F, "t6_data");

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ 4'($urandom_range(1, 15));
            address    = 3'($urandom_range(0, 7));
            chipselect = ($urandom_range(0, 3) != 0);
            write_n    = ($urandom_range(0, 2) != 0);
            writedata  = (address == 3'd5) ? 32'($urandom_range(0, 4)) : $urandom;
            cycle();
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pio_edge_capture_deb
